// File: rtl/seg7_scan_reader.sv
// Seven-segment scan reader.
// Samples a time-multiplexed 4-digit seven-segment display, waits for each
// digit/segment pair to settle, decodes it to BCD and publishes a complete
// 4-digit frame once every digit has been captured.
//
// state   | meaning
// --------+-----------------------------------------------------------
// COLLECT | gathering digit captures into the captured mask
// EMIT    | one-cycle frame publish: bcd_out/digit_err updated, valid high
module seg7_scan_reader #(
    parameter int unsigned STABLE_CYC = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:1]  seg_in,
    input  logic [3:0]  dig_en,
    input  logic        clr,
    output logic [15:0] bcd_out,
    output logic        valid,
    output logic [3:0]  digit_err,
    output logic        bus_err
);

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        EMIT    = 1'b1
    } state_t;

    localparam logic [7:0] STABLE_C = 8'(STABLE_CYC);

    state_t      state_q;
    logic [7:1]  seg_q;
    logic [3:0]  dig_q;
    logic [7:1]  seg_prev_q;
    logic [3:0]  dig_prev_q;
    logic [7:0]  cnt_q;
    logic [7:0]  cnt_d;
    logic [3:0]  mask_q;
    logic [3:0]  mask_d;
    logic [15:0] pend_q;
    logic [15:0] pend_d;
    logic [3:0]  perr_q;
    logic [3:0]  perr_d;
    logic [15:0] bcd_q;
    logic        valid_q;
    logic [3:0]  derr_q;
    logic        bus_err_q;

    logic        same;
    logic        onehot;
    logic        multihot;
    logic        capture;
    logic [4:0]  dec;

    // Map a segment pattern (g..a) to {illegal, nibble}; unknown codes give 4'hF.
    function automatic logic [4:0] decode(input logic [7:1] s);
        logic [4:0] r;
        case (s)
            7'b0111111: r = 5'h00;
            7'b0000110: r = 5'h01;
            7'b1011011: r = 5'h02;
            7'b1001111: r = 5'h03;
            7'b1100110: r = 5'h04;
            7'b1101101: r = 5'h05;
            7'b1111101: r = 5'h06;
            7'b0000111: r = 5'h07;
            7'b1111111: r = 5'h08;
            7'b1101111: r = 5'h09;
            default:    r = 5'h1F;
        endcase
        return r;
    endfunction

    // Dwell tracking, capture decision and next pending frame contents.
    always_comb begin
        multihot = (dig_q & (dig_q - 4'd1)) != 4'd0;
        onehot   = (dig_q != 4'd0) && !multihot;
        same     = {dig_q, seg_q} == {dig_prev_q, seg_prev_q};
        dec      = decode(seg_q);

        cnt_d = cnt_q;
        if (!same || !onehot) begin
            cnt_d = 8'd0;
        end else if (cnt_q < STABLE_C) begin
            cnt_d = cnt_q + 8'd1;
        end

        // Fires only on the transition into STABLE_C, so a saturated dwell
        // never captures twice.
        capture = same && onehot && (cnt_q == STABLE_C - 8'd1);

        pend_d = pend_q;
        perr_d = perr_q;
        mask_d = mask_q;
        if (capture) begin
            for (int i = 0; i < 4; i++) begin
                if (dig_q[i]) begin
                    pend_d[4*i +: 4] = dec[3:0];
                    perr_d[i]        = dec[4];
                    mask_d[i]        = 1'b1;
                end
            end
        end
    end

    // Input stage, dwell counter, frame FSM and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q      <= '0;
            dig_q      <= '0;
            seg_prev_q <= '0;
            dig_prev_q <= '0;
            cnt_q      <= '0;
            mask_q     <= '0;
            pend_q     <= '0;
            perr_q     <= '0;
            bcd_q      <= '0;
            valid_q    <= 1'b0;
            derr_q     <= '0;
            bus_err_q  <= 1'b0;
            state_q    <= COLLECT;
        end else begin
            seg_q      <= seg_in;
            dig_q      <= dig_en;
            seg_prev_q <= seg_q;
            dig_prev_q <= dig_q;
            if (clr) begin
                // Clear drops any same-cycle capture or publish.
                cnt_q     <= '0;
                mask_q    <= '0;
                perr_q    <= '0;
                bus_err_q <= 1'b0;
                valid_q   <= 1'b0;
                state_q   <= COLLECT;
            end else begin
                cnt_q  <= cnt_d;
                pend_q <= pend_d;
                perr_q <= perr_d;
                if (multihot) begin
                    bus_err_q <= 1'b1;
                end
                case (state_q)
                    COLLECT: begin
                        if (mask_d == 4'hF) begin
                            state_q <= EMIT;
                            valid_q <= 1'b1;
                            bcd_q   <= pend_d;
                            derr_q  <= perr_d;
                            mask_q  <= '0;
                        end else begin
                            valid_q <= 1'b0;
                            mask_q  <= mask_d;
                        end
                    end
                    EMIT: begin
                        // A capture landing here starts the next frame.
                        state_q <= COLLECT;
                        valid_q <= 1'b0;
                        mask_q  <= mask_d;
                    end
                    default: begin
                        state_q <= COLLECT;
                        valid_q <= 1'b0;
                        mask_q  <= '0;
                    end
                endcase
            end
        end
    end

    assign bcd_out   = bcd_q;
    assign valid     = valid_q;
    assign digit_err = derr_q;
    assign bus_err   = bus_err_q;

endmodule

// File: doc/seg7_scan_reader.md
SEG7_SCAN_READER -- requirements
Module: seg7_scan_reader

Interface
REQ-001 Parameter STABLE_CYC, default 4, range 1..255: consecutive cycles a sampled segment/digit pair must hold unchanged before capture.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 seg_in  input  7 [7:1]  segment lines, active-high, bit order g f e d c b a (seg_in[1]=a, seg_in[7]=g).
REQ-005 dig_en  input  4  digit select from a time-multiplexed display, active-high, one-hot legal; bit i selects digit i (bit 0 = least significant).
REQ-006 clr  input  1  synchronous clear of frame progress and error flags.
REQ-007 bcd_out  output  16  last complete frame, digit i in bits [4i+3:4i], registered.
REQ-008 valid  output  1  one-cycle pulse; bcd_out updated this cycle.
REQ-009 digit_err  output  4  per-digit flag; bit i = last capture of digit i was not a legal code, registered with bcd_out.
REQ-010 bus_err  output  1  sticky; a multi-hot dig_en was sampled.

Function
REQ-011 Input stage SHALL register {dig_en, seg_in} every cycle; all later logic uses only the registered copy.
REQ-012 Stability counter SHALL increment, saturating at STABLE_CYC, while the registered pair is unchanged from the previous cycle and dig_en is one-hot; any change, all-zero, or multi-hot dig_en SHALL reset it to 0.
REQ-013 Capture SHALL occur exactly once per dwell: on the cycle the counter reaches STABLE_CYC; no further capture until the counter has been reset.
REQ-014 Inputs held constant from edge k SHALL produce capture at edge k+STABLE_CYC+1.
REQ-015 Decode table (seg_in[7:1] -> digit): 0111111->0, 0000110->1, 1011011->2, 1001111->3, 1100110->4, 1101101->5, 1111101->6, 0000111->7, 1111111->8, 1101111->9.
REQ-016 Any other pattern, including all-off, SHALL store nibble 4'hF and set the pending error bit for that digit; a legal capture SHALL clear that pending bit.
REQ-017 Each capture SHALL write the selected digit's pending nibble and set its bit in a 4-bit captured mask; recapture of a digit before frame completion SHALL overwrite it.
REQ-018 Frame FSM states COLLECT and EMIT: COLLECT -> EMIT when mask is 4'b1111 after the edge; EMIT lasts one cycle, copies pending nibbles to bcd_out and pending error bits to digit_err, asserts valid, clears mask, returns to COLLECT.
REQ-019 valid SHALL be high the cycle after the edge of the fourth distinct-digit capture; a capture arriving in the EMIT cycle SHALL count toward the next frame.
REQ-020 Multi-hot dig_en sample SHALL set bus_err; all-zero dig_en (blanking) SHALL NOT set bus_err.
REQ-021 clr SHALL clear mask, pending error bits, bus_err and the stability counter and force COLLECT; it SHALL NOT alter bcd_out or digit_err; clr wins over a same-cycle capture or EMIT (no valid that cycle).
REQ-022 No combinational path from inputs to outputs.

Reset
REQ-023 rst_n low SHALL immediately force: bcd_out=16'h0000, valid=0, digit_err=4'h0, bus_err=0, mask=0, counter=0, input registers=0, state COLLECT.
REQ-024 Reset asserted mid-frame SHALL discard all partial captures; first valid after release requires four fresh captures.

Verification
REQ-025 STABLE_CYC=4; scan digits 0..3 with patterns for 1,2,3,4, each held 6 cycles -> single valid pulse, bcd_out=16'h4321, digit_err=0.
REQ-026 Hold digit 0 with 0000110 for 3 cycles then change pattern -> no capture; hold 4 cycles -> capture at edge k+5, exactly one.
REQ-027 Digit 2 shows 1110111 ('A') within a full scan of 9,8,A,7 -> bcd_out=16'h7F89, digit_err=4'b0100; next clean frame clears digit_err bit 2.
REQ-028 dig_en=4'b0011 for 2 cycles during scan -> bus_err=1, no capture; clr pulse -> bus_err=0, bcd_out unchanged.
REQ-029 rst_n low after three captures, release, capture one digit -> no valid; all outputs zero during reset.
REQ-030 clr asserted the same cycle as the fourth capture completes -> no valid, mask=0, bcd_out retains previous frame.
